// File: rtl/store_buffer_pkg.sv
// Shared bus widths, store-size encodings, drain FSM states and the buffered-store
// entry layout.
package store_buffer_pkg;

  localparam int unsigned ADDR_BUS    = 32;
  localparam int unsigned DATA_BUS    = 32;
  localparam int unsigned MEM_SEL_BUS = 4;
  localparam int unsigned WADDR_W     = ADDR_BUS - 2;

  localparam logic [MEM_SEL_BUS-1:0] SEL_BYTE = 4'b0001;
  localparam logic [MEM_SEL_BUS-1:0] SEL_HALF = 4'b0011;
  localparam logic [MEM_SEL_BUS-1:0] SEL_WORD = 4'b1111;

  typedef enum logic {
    STB_IDLE  = 1'b0,
    STB_WRITE = 1'b1
  } stb_state_e;

  typedef struct packed {
    logic [WADDR_W-1:0]     waddr;
    logic [DATA_BUS-1:0]    data;
    logic [MEM_SEL_BUS-1:0] sel;
  } stb_entry_t;

endpackage

// File: rtl/store_align.sv
// Places a right-justified store value into RAM byte lanes and generates the
// matching byte-select. Flags misaligned or illegal-size requests.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]             addr_lo,
  input  logic [DATA_BUS-1:0]    data_in,
  input  logic [MEM_SEL_BUS-1:0] sel_in,
  output logic [DATA_BUS-1:0]    data_out,
  output logic [MEM_SEL_BUS-1:0] sel_out,
  output logic                   err
);

  always_comb begin
    data_out = '0;
    sel_out  = '0;
    err      = 1'b0;
    case (sel_in)
      SEL_BYTE: begin
        data_out = {4{data_in[7:0]}};
        sel_out  = SEL_BYTE << addr_lo;
      end
      SEL_HALF: begin
        data_out = {2{data_in[15:0]}};
        if (addr_lo[0]) err = 1'b1;
        else            sel_out = addr_lo[1] ? 4'b1100 : SEL_HALF;
      end
      SEL_WORD: begin
        data_out = data_in;
        if (addr_lo != 2'b00) err = 1'b1;
        else                  sel_out = SEL_WORD;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Small FIFO of lane-aligned stores drained to the data RAM over valid/ack, with
// a conservative word-address alias check for the load in MEM.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [ADDR_BUS-1:0]    st_addr,
  input  logic [DATA_BUS-1:0]    st_data,
  input  logic [MEM_SEL_BUS-1:0] st_sel,
  output logic                   st_ready,
  output logic                   st_addr_err,
  input  logic [ADDR_BUS-1:0]    ld_addr,
  output logic                   ld_hit,
  output logic                   busy,
  output logic                   ram_write_en,
  output logic [ADDR_BUS-1:0]    ram_addr,
  output logic [DATA_BUS-1:0]    ram_write_data,
  output logic [MEM_SEL_BUS-1:0] ram_write_sel,
  input  logic                   ram_ack
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  stb_state_e       state_q, state_d;
  stb_entry_t       mem_q [DEPTH];
  stb_entry_t       mem_d [DEPTH];

  logic [DATA_BUS-1:0]    al_data;
  logic [MEM_SEL_BUS-1:0] al_sel;
  logic                   al_err;
  logic                   enq, deq;
  stb_entry_t             head_entry;
  logic                   unused_ld_lo;

  store_align u_align (
    .addr_lo  (st_addr[1:0]),
    .data_in  (st_data),
    .sel_in   (st_sel),
    .data_out (al_data),
    .sel_out  (al_sel),
    .err      (al_err)
  );

  assign st_ready     = (count_q != CNT_W'(DEPTH));
  assign st_addr_err  = al_err;
  assign enq          = st_valid && st_ready && !al_err;
  assign deq          = (state_q == STB_WRITE) && ram_ack;
  assign unused_ld_lo = ^ld_addr[1:0];

  // FIFO bookkeeping and drain FSM next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    state_d = state_q;
    if (enq) begin
      mem_d[tail_q] = '{waddr: st_addr[ADDR_BUS-1:2], data: al_data, sel: al_sel};
      tail_d        = tail_q + PTR_W'(1);
    end
    if (deq) head_d = head_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      STB_IDLE:  if (count_d != '0) state_d = STB_WRITE;
      STB_WRITE: if (count_d == '0) state_d = STB_IDLE;
      default:   state_d = STB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= STB_IDLE;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      mem_q   <= mem_d;
    end
  end

  // RAM port shows the head entry only while writing; zeros otherwise
  assign head_entry     = mem_q[head_q];
  assign ram_write_en   = (state_q == STB_WRITE);
  assign ram_addr       = ram_write_en ? {head_entry.waddr, 2'b00} : '0;
  assign ram_write_data = ram_write_en ? head_entry.data : '0;
  assign ram_write_sel  = ram_write_en ? head_entry.sel : '0;
  assign busy           = (count_q != '0);

  // An entry is live when its distance from head is below count
  always_comb begin
    logic [PTR_W-1:0] off;
    ld_hit = 1'b0;
    off    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head_q;
      if ((CNT_W'(off) < count_q) && (mem_q[i].waddr == ld_addr[ADDR_BUS-1:2]))
        ld_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: alignment vector table, directed FIFO corner cases and
// a randomized run against a queue-based reference model.
module tb_store_buffer;

  logic        clk, rst;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic [3:0]  st_sel;
  logic        st_ready, st_addr_err;
  logic [31:0] ld_addr;
  logic        ld_hit, busy, ram_write_en;
  logic [31:0] ram_addr, ram_write_data;
  logic [3:0]  ram_write_sel;
  logic        ram_ack;

  int n_tests = 0;
  int n_fail  = 0;

  store_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_sel(st_sel), .st_ready(st_ready), .st_addr_err(st_addr_err), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .busy(busy), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_write_sel(ram_write_sel), .ram_ack(ram_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_sel;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } ent_t;

  ent_t model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference alignment: lane j takes byte (j mod size) of the value
  function automatic void model_align(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, output logic err,
                                      output logic [31:0] data, output logic [3:0] sel);
    int size, k;
    size = (s == 4'h1) ? 1 : (s == 4'h3) ? 2 : (s == 4'hF) ? 4 : 0;
    k    = int'(a[1:0]);
    data = '0;
    sel  = '0;
    err  = (size == 0) || ((k % ((size == 0) ? 1 : size)) != 0);
    if (size != 0) begin
      sel = 4'(((1 << size) - 1) << k);
      for (int j = 0; j < 4; j++) data[8*j +: 8] = d[8*(j % size) +: 8];
    end
  endfunction

  task automatic put(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    st_valid = v; st_addr = a; st_data = d; st_sel = s;
  endtask

  vec_t vecs[10];

  initial begin
    rst = 1'b1; ram_ack = 1'b0; ld_addr = '0;
    put(1'b0, '0, '0, 4'hF);
    vecs[0] = '{32'h1003, 32'h000000AB, 4'b0001, 1'b0, 32'h1000, 32'hABABABAB, 4'b1000};
    vecs[1] = '{32'h2002, 32'h00001234, 4'b0011, 1'b0, 32'h2000, 32'h12341234, 4'b1100};
    vecs[2] = '{32'h2001, 32'h00001234, 4'b0011, 1'b1, 32'h0, 32'h0, 4'h0};
    vecs[3] = '{32'h3004, 32'h11223344, 4'b0111, 1'b1, 32'h0, 32'h0, 4'h0};
    vecs[4] = '{32'h0041, 32'hFFFFFF5A, 4'b0001, 1'b0, 32'h0040, 32'h5A5A5A5A, 4'b0010};
    vecs[5] = '{32'h0050, 32'hDEADBEEF, 4'b0011, 1'b0, 32'h0050, 32'hBEEFBEEF, 4'b0011};
    vecs[6] = '{32'h0060, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0060, 32'hCAFEF00D, 4'b1111};
    vecs[7] = '{32'h0062, 32'hCAFEF00D, 4'b1111, 1'b1, 32'h0, 32'h0, 4'h0};
    vecs[8] = '{32'h0070, 32'h12345678, 4'b0000, 1'b1, 32'h0, 32'h0, 4'h0};
    vecs[9] = '{32'h0073, 32'h12345678, 4'b0011, 1'b1, 32'h0, 32'h0, 4'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wen", 32'(ram_write_en), 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_data", ram_write_data, 32'd0);
    chk("rst_sel", 32'(ram_write_sel), 32'd0);
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Alignment table: one store, inspect RAM port, then retire
    foreach (vecs[i]) begin
      @(negedge clk);
      put(1'b1, vecs[i].addr, vecs[i].data, vecs[i].sel);
      #1 chk($sformatf("v%0d_err", i), 32'(st_addr_err), 32'(vecs[i].err));
      @(negedge clk);
      put(1'b0, '0, '0, 4'hF);
      #1;
      if (vecs[i].err) begin
        chk($sformatf("v%0d_busy_err", i), 32'(busy), 32'd0);
      end else begin
        chk($sformatf("v%0d_wen", i), 32'(ram_write_en), 32'd1);
        chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].r_addr);
        chk($sformatf("v%0d_data", i), ram_write_data, vecs[i].r_data);
        chk($sformatf("v%0d_sel", i), 32'(ram_write_sel), 32'(vecs[i].r_sel));
        ram_ack = 1'b1;
        @(negedge clk) ram_ack = 1'b0;
        #1 chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
      end
    end

    // Fill with no ack, third store ignored, alias check, in-order retire
    @(negedge clk) put(1'b1, 32'h10, 32'h1, 4'hF);
    @(negedge clk) put(1'b1, 32'h20, 32'h2, 4'hF);
    @(negedge clk) put(1'b1, 32'h30, 32'h3, 4'hF);
    #1 chk("fill_ready", 32'(st_ready), 32'd0);
    ld_addr = 32'h22;
    #1 chk("ld_hit_22", 32'(ld_hit), 32'd1);
    ld_addr = 32'h30;
    #1 chk("ld_hit_30", 32'(ld_hit), 32'd0);
    @(negedge clk) put(1'b0, '0, '0, 4'hF);
    #1 chk("fill_head0", ram_addr, 32'h10);
    ram_ack = 1'b1;
    @(negedge clk);
    #1 chk("fill_head1", ram_addr, 32'h20);
    chk("fill_ready1", 32'(st_ready), 32'd1);
    @(negedge clk) ram_ack = 1'b0;
    #1 chk("fill_drained", 32'(busy), 32'd0);

    // Full buffer: enqueue blocked even with a same-cycle retire
    @(negedge clk) put(1'b1, 32'h10, 32'h1, 4'hF);
    @(negedge clk) put(1'b1, 32'h20, 32'h2, 4'hF);
    @(negedge clk) begin put(1'b1, 32'h30, 32'h3, 4'hF); ram_ack = 1'b1; end
    @(negedge clk) begin put(1'b0, '0, '0, 4'hF); ram_ack = 1'b0; end
    #1 chk("full_ack_ready", 32'(st_ready), 32'd1);
    chk("full_ack_head", ram_addr, 32'h20);
    ram_ack = 1'b1;
    @(negedge clk) ram_ack = 1'b0;
    #1 chk("full_ack_blocked", 32'(busy), 32'd0);

    // Steady state: one store per cycle with continuous ack, pointers wrap
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      put(1'b1, 32'h100 + 32'(4*i), 32'(i), 4'hF);
      ram_ack = (i > 0);
      #1;
      if (i > 0) begin
        chk($sformatf("steady%0d_addr", i), ram_addr, 32'h100 + 32'(4*(i-1)));
        chk($sformatf("steady%0d_ready", i), 32'(st_ready), 32'd1);
      end
    end
    @(negedge clk) begin put(1'b0, '0, '0, 4'hF); ram_ack = 1'b1; end
    #1 chk("steady_last", ram_addr, 32'h11C);
    @(negedge clk) ram_ack = 1'b0;
    #1 chk("steady_empty", 32'(busy), 32'd0);

    // Async reset while a write waits for ack
    @(negedge clk) put(1'b1, 32'h40, 32'h44, 4'hF);
    @(negedge clk) put(1'b0, '0, '0, 4'hF);
    #1 chk("mid_wen_before", 32'(ram_write_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wen", 32'(ram_write_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(st_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    model_q.delete();

    // Randomized run against the queue model
    for (int c = 0; c < 400; c++) begin
      logic        m_err, do_enq, do_deq;
      logic [31:0] m_data;
      logic [3:0]  m_sel, s;
      logic        hit;
      ent_t        e;
      @(negedge clk);
      case ($urandom_range(0, 4))
        0: s = 4'h1;
        1: s = 4'h3;
        2: s = 4'hF;
        3: s = 4'hF;
        default: s = 4'($urandom_range(0, 15));
      endcase
      put(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 31)), $urandom, s);
      ram_ack = 1'($urandom_range(0, 2) != 0);
      ld_addr = 32'h100 + 32'($urandom_range(0, 31));
      #1;
      model_align(st_addr, st_data, st_sel, m_err, m_data, m_sel);
      hit = 1'b0;
      foreach (model_q[j]) if (model_q[j].addr[31:2] == ld_addr[31:2]) hit = 1'b1;
      chk("rnd_err", 32'(st_addr_err), 32'(m_err));
      chk("rnd_ready", 32'(st_ready), 32'(model_q.size() < 2));
      chk("rnd_busy", 32'(busy), 32'(model_q.size() != 0));
      chk("rnd_ld_hit", 32'(ld_hit), 32'(hit));
      chk("rnd_wen", 32'(ram_write_en), 32'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        chk("rnd_addr", ram_addr, {model_q[0].addr[31:2], 2'b00});
        chk("rnd_data", ram_write_data, model_q[0].data);
        chk("rnd_sel", 32'(ram_write_sel), 32'(model_q[0].sel));
      end else begin
        chk("rnd_addr_idle", ram_addr, 32'd0);
      end
      do_deq = ram_ack && (model_q.size() != 0);
      do_enq = st_valid && (model_q.size() < 2) && !m_err;
      e = '{st_addr, m_data, m_sel};
      @(posedge clk);
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
